// File: rtl/hilo_md_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : hilo_md_ctrl
// Brief   : MULT/MULTU/DIV/DIVU sequencer producing HI/LO results
// Revision: 1.0 - initial release
// ============================================================================
module hilo_md_ctrl #(
    parameter int MUL_LAT        = 2,
    parameter bit DIV_EARLY_ZERO = 1'b1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        md_start,
    input  logic [1:0]  md_op,
    input  logic [31:0] md_src1,
    input  logic [31:0] md_src2,
    input  logic        cancel,
    output logic        md_busy,
    output logic        md_done,
    output logic [31:0] md_hi,
    output logic [31:0] md_lo,
    output logic        md_div0
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [5:0] C_MUL_LAST = 6'(MUL_LAT - 2);
    localparam logic [5:0] C_DIV_LAST = 6'd31;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q;
    logic [31:0] quo_q, rem_q, dvs_q, src1_q;
    logic        neg_quo_q, neg_rem_q, dvz_q;
    logic [63:0] prod_q;
    logic [31:0] hi_q, lo_q;
    logic        div0_q;

    logic        w_accept, w_is_div, w_signed, w_s1neg, w_s2neg, w_src2_zero, w_early;
    logic [31:0] w_mag1, w_mag2;
    logic [63:0] w_opa, w_opb, w_prod;
    logic [32:0] w_rem_sh;
    logic        w_fits;
    logic [31:0] w_trial, w_rem_step, w_quo_step, w_quo_fin, w_rem_fin;
    logic        w_load, w_res_div0;
    logic [63:0] w_res;

    assign w_accept    = ((state_q == S_IDLE) || (state_q == S_DONE)) && md_start && !cancel;
    assign w_is_div    = md_op[1];
    assign w_signed    = !md_op[0];
    assign w_s1neg     = w_signed & md_src1[31];
    assign w_s2neg     = w_signed & md_src2[31];
    assign w_src2_zero = (md_src2 == 32'd0);
    assign w_early     = w_is_div && w_src2_zero && DIV_EARLY_ZERO;
    assign w_mag1      = w_s1neg ? (~md_src1 + 32'd1) : md_src1;
    assign w_mag2      = w_s2neg ? (~md_src2 + 32'd1) : md_src2;

    // A 64x64 product truncated to 64 bits is exact for both signednesses
    // once the operands are extended the right way.
    assign w_opa  = w_signed ? {{32{md_src1[31]}}, md_src1} : {32'd0, md_src1};
    assign w_opb  = w_signed ? {{32{md_src2[31]}}, md_src2} : {32'd0, md_src2};
    assign w_prod = w_opa * w_opb;

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    assign w_rem_sh   = {rem_q, quo_q[31]};
    assign w_fits     = (w_rem_sh >= {1'b0, dvs_q});
    assign w_trial    = w_rem_sh[31:0] - dvs_q;
    assign w_rem_step = w_fits ? w_trial : w_rem_sh[31:0];
    assign w_quo_step = {quo_q[30:0], w_fits};
    assign w_quo_fin  = neg_quo_q ? (~w_quo_step + 32'd1) : w_quo_step;
    assign w_rem_fin  = neg_rem_q ? (~w_rem_step + 32'd1) : w_rem_step;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (w_accept) begin
                    if (!w_is_div)
                        state_d = (MUL_LAT == 1) ? S_DONE : S_MUL;
                    else if (w_early)
                        state_d = S_DONE;
                    else
                        state_d = S_DIV;
                end
            end
            S_MUL:   if (cnt_q == C_MUL_LAST) state_d = S_DONE;
            S_DIV:   if (cnt_q == C_DIV_LAST) state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
        if (cancel)
            state_d = S_IDLE;
    end

    assign w_load = (state_d == S_DONE);

    always_comb begin
        w_res      = prod_q;
        w_res_div0 = 1'b0;
        if (w_accept) begin
            if (w_is_div) begin
                w_res      = {md_src1, 32'hFFFF_FFFF};
                w_res_div0 = 1'b1;
            end else begin
                w_res = w_prod;
            end
        end else if (state_q == S_DIV) begin
            if (dvz_q) begin
                w_res      = {src1_q, 32'hFFFF_FFFF};
                w_res_div0 = 1'b1;
            end else begin
                w_res = {w_rem_fin, w_quo_fin};
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q     <= 6'd0;
            quo_q     <= 32'd0;
            rem_q     <= 32'd0;
            dvs_q     <= 32'd0;
            src1_q    <= 32'd0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dvz_q     <= 1'b0;
            prod_q    <= 64'd0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            div0_q    <= 1'b0;
        end else begin
            if (cancel) begin
                cnt_q <= 6'd0;
                rem_q <= 32'd0;
            end else if (w_accept) begin
                cnt_q     <= 6'd0;
                quo_q     <= w_mag1;
                rem_q     <= 32'd0;
                dvs_q     <= w_mag2;
                src1_q    <= md_src1;
                neg_quo_q <= w_s1neg ^ w_s2neg;
                neg_rem_q <= w_s1neg;
                dvz_q     <= w_src2_zero;
                prod_q    <= w_prod;
            end else if (state_q == S_DIV) begin
                cnt_q <= cnt_q + 6'd1;
                quo_q <= w_quo_step;
                rem_q <= w_rem_step;
            end else if (state_q == S_MUL) begin
                cnt_q <= cnt_q + 6'd1;
            end

            // Results change only when DONE is entered; an early-zero accept
            // enters DONE directly, so the load takes priority over the clear.
            if (w_load) begin
                hi_q   <= w_res[63:32];
                lo_q   <= w_res[31:0];
                div0_q <= w_res_div0;
            end else if (w_accept) begin
                div0_q <= 1'b0;
            end
        end
    end

    assign md_busy = (state_q == S_MUL) || (state_q == S_DIV);
    assign md_done = (state_q == S_DONE);
    assign md_hi   = hi_q;
    assign md_lo   = lo_q;
    assign md_div0 = div0_q;

endmodule
`default_nettype wire
